// File: rtl/hd_memory_ctrl.sv
// Hypervector memory controller: word, row and streamed-row writes into a flop array,
// plus registered read-before-write row reads.
module hd_memory_ctrl #(
    parameter int unsigned ROW_WIDTH  = 512,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_ROWS   = 16,
    localparam int unsigned WPR = ROW_WIDTH / WORD_WIDTH,
    localparam int unsigned RAW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned WAW = $clog2(WPR)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            mode_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [RAW-1:0]        row_addr_i,
    input  logic [WAW-1:0]        word_addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_word_i,
    input  logic [ROW_WIDTH-1:0]  wdata_row_i,
    input  logic                  rd_en_i,
    input  logic [RAW-1:0]        rd_row_addr_i,
    output logic [ROW_WIDTH-1:0]  rdata_row_o,
    output logic                  busy_o,
    output logic                  error_o
);

    localparam logic [1:0] ModeWord   = 2'd0;
    localparam logic [1:0] ModeRow    = 2'd1;
    localparam logic [1:0] ModeStream = 2'd2;

    typedef enum logic [1:0] {StIdle, StStream, StCommit} state_e;

    state_e                r_state, w_state_nxt;
    logic [ROW_WIDTH-1:0]  r_mem [NUM_ROWS];
    logic [ROW_WIDTH-1:0]  r_buf;
    logic [ROW_WIDTH-1:0]  r_rdata;
    logic [WAW-1:0]        r_cnt, w_cnt_nxt;
    logic [RAW-1:0]        r_row;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_row_ok, w_rd_ok;
    logic [ROW_WIDTH-1:0]  w_rd_row;
    logic                  w_word_we, w_row_we, w_buf_we, w_commit, w_latch_row, w_wr_err;

    assign w_accept    = req_valid_i && req_ready_o;
    assign req_ready_o = (r_state != StCommit);
    assign busy_o      = (r_state != StIdle);
    assign error_o     = r_error;
    assign rdata_row_o = r_rdata;

    // Address decode doubles as the range check for non-power-of-two row counts.
    always_comb begin
        w_row_ok = 1'b0;
        w_rd_ok  = 1'b0;
        w_rd_row = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (row_addr_i == RAW'(r)) begin
                w_row_ok = 1'b1;
            end
            if (rd_row_addr_i == RAW'(r)) begin
                w_rd_ok  = 1'b1;
                w_rd_row = r_mem[r];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_we   = 1'b0;
        w_row_we    = 1'b0;
        w_buf_we    = 1'b0;
        w_commit    = 1'b0;
        w_latch_row = 1'b0;
        w_wr_err    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (!w_row_ok) begin
                        w_wr_err = 1'b1;
                    end else begin
                        case (mode_i)
                            ModeWord: w_word_we = 1'b1;
                            ModeRow:  w_row_we  = 1'b1;
                            ModeStream: begin
                                w_buf_we    = 1'b1;
                                w_latch_row = 1'b1;
                                w_cnt_nxt   = WAW'(1);
                                w_state_nxt = StStream;
                            end
                            default: w_wr_err = 1'b1;
                        endcase
                    end
                end
            end
            StStream: begin
                if (w_accept) begin
                    w_buf_we  = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == WAW'(WPR - 1)) begin
                        w_state_nxt = StCommit;
                    end
                end
            end
            StCommit: begin
                w_commit    = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_row   <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch_row) begin
                r_row <= row_addr_i;
            end
            if (w_buf_we) begin
                r_buf[r_cnt*WORD_WIDTH +: WORD_WIDTH] <= wdata_word_i;
            end
            // Read and write errors on the same edge merge into one pulse.
            r_error <= w_wr_err | (rd_en_i & ~w_rd_ok);
            if (rd_en_i) begin
                r_rdata <= w_rd_row;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                if (w_commit && r_row == RAW'(r)) begin
                    r_mem[r] <= r_buf;
                end else if (w_row_we && row_addr_i == RAW'(r)) begin
                    r_mem[r] <= wdata_row_i;
                end else if (w_word_we && row_addr_i == RAW'(r)) begin
                    r_mem[r][word_addr_i*WORD_WIDTH +: WORD_WIDTH] <= wdata_word_i;
                end
            end
        end
    end

endmodule

// File: doc/hd_memory_ctrl.md
# hd_memory_ctrl

Parametrised write/read controller for the hypervector memory of the HD accelerator. It generalises the two-mode (word/row) write scheme to arbitrary row width, word width and row count. It adds a third mode, StreamMode, which assembles a full row from consecutive word beats under a valid/ready handshake and commits it atomically. It sits between the accelerator's encoder/config datapath and the associative-memory search logic, which reads full rows.

## Interface
- ROW_WIDTH, 512, bits per hypervector row
- WORD_WIDTH, 32, bits per word beat; ROW_WIDTH % WORD_WIDTH == 0; WPR = ROW_WIDTH/WORD_WIDTH ≥ 2
- NUM_ROWS, 16, number of rows; RAW = max(1,$clog2(NUM_ROWS)), WAW = $clog2(WPR)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- mode_i  in  2  0 WordMode, 1 RowMode, 2 StreamMode, 3 reserved
- req_valid_i  in  1  write request/beat valid
- req_ready_o  out  1  controller accepts beat
- row_addr_i  in  RAW  target row
- word_addr_i  in  WAW  word index (WordMode only)
- wdata_word_i  in  WORD_WIDTH  word data (WordMode, StreamMode)
- wdata_row_i  in  ROW_WIDTH  row data (RowMode)
- rd_en_i  in  1  read request
- rd_row_addr_i  in  RAW  read row
- rdata_row_o  out  ROW_WIDTH  registered read data
- busy_o  out  1  stream in progress (STREAM or COMMIT)
- error_o  out  1  one-cycle pulse on rejected request

## Operation
- Storage: NUM_ROWS × ROW_WIDTH flops, all cleared to 0 on reset. Staging buffer ROW_WIDTH flops, word counter WAW bits, latched row register RAW bits.
- A beat is accepted when req_valid_i && req_ready_o at a rising edge.
- FSM IDLE / STREAM / COMMIT; reset → IDLE.
- IDLE: req_ready_o=1. On an accepted beat:
  - WordMode: row[row_addr_i][word_addr_i*WORD_WIDTH +: WORD_WIDTH] <= wdata_word_i; other bits untouched.
  - RowMode: row[row_addr_i] <= wdata_row_i.
  - StreamMode: latch row_addr_i; buffer word 0 <= wdata_word_i; counter <= 1; → STREAM.
  - mode 3, or row_addr_i ≥ NUM_ROWS: no state change, no write; error_o=1 next cycle.
- STREAM: req_ready_o=1. Each accepted beat writes buffer word[counter] and increments the counter. mode_i, row_addr_i and word_addr_i are ignored. The beat with counter==WPR-1 → COMMIT. Gaps (valid low) are allowed indefinitely.
- COMMIT: req_ready_o=0; row[latched] <= buffer at the edge ending the cycle; counter <= 0; → IDLE.
- Read: on rd_en_i at an edge, rdata_row_o <= row[rd_row_addr_i] as stored before that edge's write (read-before-write). Without rd_en_i, rdata_row_o holds its value. A read with rd_row_addr_i ≥ NUM_ROWS returns 0 and pulses error_o.
- Reads are independent of the FSM and allowed in every state.
- Mid-stream reads of the target row return the old contents. The buffer is never visible until commit.

## Timing
- Reset values: req_ready_o=1, busy_o=0, error_o=0, rdata_row_o=0, memory=0, buffer=0, counter=0.
- Word/Row write: visible to a read sampled one edge after the accepting edge. A read on the same edge returns old data.
- Stream: WPR accepted beats, then 1 COMMIT cycle. Minimum WPR+1 cycles from first beat to return to IDLE. The new row is readable by a read sampled at the edge after COMMIT ends.
- busy_o=1 from the edge accepting beat 0 through the end of COMMIT.
- error_o is registered: high exactly one cycle after the offending edge. Simultaneous write error and read error produce a single pulse.
- Async reset mid-stream: FSM → IDLE immediately, buffer discarded, memory cleared.
- Back-to-back: a new request may be accepted in the first IDLE cycle after COMMIT.

## Test plan
- Reset then read rows 0 and NUM_ROWS-1 → rdata_row_o=0. After reset, req_ready_o=1, busy_o=0.
- RowMode write row 3 = {16{32'hA5A5_0000+i}}; WordMode write row 3 word 5 = 32'hDEAD_BEEF; read row 3 → only bits [191:160] changed.
- StreamMode row 7, 16 beats 32'h1..32'h10 with valid gaps after beats 4 and 11. Read row 7 during the stream → old value. busy_o drops after COMMIT. Read row 7 → word i = i+1. req_ready_o=0 exactly during COMMIT.
- Same-edge write and read of row 2 (RowMode 0xFF..F) → read returns the previous content; the next read returns all ones.
- mode_i=3, then a WordMode write with row_addr_i=16 (NUM_ROWS=16, RAW=4 stores 0..15, so use NUM_ROWS=12, row 13) → error_o one-cycle pulses, memory unchanged.
- Assert rst_ni low after beat 9 of a stream → FSM IDLE, busy_o=0. Restarting a stream to the same row commits only the new data.
